// File: rtl/decode_pkg.sv
// Shared opcode, format and state encodings for the RV32I decode stage.
package decode_pkg;

  localparam int unsigned XLEN_W = 32;

  localparam logic [6:0] OP       = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] LOAD     = 7'b0000011;
  localparam logic [6:0] STORE    = 7'b0100011;
  localparam logic [6:0] BRANCH   = 7'b1100011;
  localparam logic [6:0] JAL      = 7'b1101111;
  localparam logic [6:0] JALR     = 7'b1100111;
  localparam logic [6:0] LUI      = 7'b0110111;
  localparam logic [6:0] AUIPC    = 7'b0010111;
  localparam logic [6:0] SYSTEM   = 7'b1110011;
  localparam logic [6:0] MISC_MEM = 7'b0001111;

  localparam logic [2:0] FMT_R    = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
  localparam logic [2:0] FMT_NONE = 3'd7;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StFull  = 2'd1,
    StSkid  = 2'd2,
    StHalt  = 2'd3
  } state_e;

  typedef struct packed {
    logic [XLEN_W-1:0] instr;
    logic [XLEN_W-1:0] pc;
    logic [2:0]        fmt;
    logic [XLEN_W-1:0] imm;
  } beat_t;

endpackage

// File: rtl/decode_stage_ctrl_imm_gen.sv
// Immediate generator: builds the sign-extended immediate for a given instruction format.
module decode_stage_ctrl_imm_gen
  import decode_pkg::*;
(
  input  logic [31:7] instr_i,
  input  logic [2:0]  fmt_i,
  output logic [31:0] imm_o
);

  always_comb begin
    imm_o = '0;
    case (fmt_i)
      FMT_I: imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
      FMT_S: imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      FMT_B: imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                      instr_i[11:8], 1'b0};
      FMT_U: imm_o = {instr_i[31:12], 12'b0};
      FMT_J: imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                      instr_i[30:21], 1'b0};
      default: imm_o = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage_ctrl.sv
// Registered decode stage with 2-entry skid buffer and flush.
// Optional illegal-opcode trap/halt enabled by defining DECODE_ILLEGAL_TRAP_EN.
module decode_stage_ctrl
  import decode_pkg::*;
#(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_PC_TAG = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [2:0]      out_fmt,
  output logic [XLEN-1:0] out_imm,
  output logic            out_illegal
);

`ifdef DECODE_ILLEGAL_TRAP_EN
  localparam bit TrapEn = 1'b1;
`else
  localparam bit TrapEn = 1'b0;
`endif

  state_e      state_q, state_d;
  logic        in_ready_q, in_ready_d;
  beat_t       m_q, m_d;
  beat_t       k_q, k_d;
  logic [2:0]  in_fmt;
  logic [31:0] in_imm;
  beat_t       in_beat;
  logic        in_xfer, out_xfer;
  logic        m_traps;

  always_comb begin
    in_fmt = FMT_NONE;
    case (in_instr[6:0])
      OP:                                      in_fmt = FMT_R;
      OP_IMM, LOAD, JALR, SYSTEM, MISC_MEM:    in_fmt = FMT_I;
      STORE:                                   in_fmt = FMT_S;
      BRANCH:                                  in_fmt = FMT_B;
      LUI, AUIPC:                              in_fmt = FMT_U;
      JAL:                                     in_fmt = FMT_J;
      default:                                 in_fmt = FMT_NONE;
    endcase
  end

  decode_stage_ctrl_imm_gen u_imm_gen (
    .instr_i (in_instr[31:7]),
    .fmt_i   (in_fmt),
    .imm_o   (in_imm)
  );

  assign in_beat  = '{instr: in_instr, pc: in_pc, fmt: in_fmt, imm: in_imm};
  assign in_xfer  = in_valid & in_ready_q;
  assign out_xfer = out_valid & out_ready;
  assign m_traps  = TrapEn & (m_q.fmt == FMT_NONE);

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    k_d     = k_q;
    case (state_q)
      StEmpty: begin
        if (in_xfer) begin
          m_d     = in_beat;
          state_d = StFull;
        end
      end
      StFull: begin
        if (in_xfer && out_xfer) begin
          m_d = in_beat;
        end else if (out_xfer) begin
          state_d = m_traps ? StHalt : StEmpty;
        end else if (in_xfer) begin
          k_d     = in_beat;
          state_d = StSkid;
        end
      end
      StSkid: begin
        if (out_xfer) begin
          m_d     = k_q;
          state_d = StFull;
        end
      end
      StHalt:  state_d = StHalt;
      default: state_d = StEmpty;
    endcase
    if (flush) begin
      state_d = StEmpty;
    end
    // An illegal beat in M closes the input so nothing queues behind the trap.
    in_ready_d = (state_d == StEmpty) ||
                 ((state_d == StFull) && !(TrapEn && (m_d.fmt == FMT_NONE)));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StEmpty;
      in_ready_q <= 1'b1;
      m_q        <= '0;
      k_q        <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      m_q        <= m_d;
      k_q        <= k_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = (state_q == StFull) || (state_q == StSkid);
  assign out_instr   = out_valid ? m_q.instr : '0;
  assign out_pc      = out_valid ? m_q.pc : RESET_PC_TAG;
  assign out_fmt     = out_valid ? m_q.fmt : FMT_NONE;
  assign out_imm     = out_valid ? m_q.imm : '0;
  assign out_illegal = out_valid & m_traps;

endmodule

// File: doc/decode_stage_ctrl.md
Name: decode_stage_ctrl

Overview:
- Registered decode-stage controller between instruction fetch and execute in the RV32I core.
- Accepts instruction/PC beats over a valid/ready handshake and classifies the instruction format.
- Produces the sign-extended immediate through one internal immediate generator.
- Holds results in a 2-entry skid buffer so ready never combinationally depends on downstream ready; also handles flush for taken branches and jumps.

Parameters:
- XLEN, 32, datapath width for instruction, PC and immediate (only 32 supported).
- RESET_PC_TAG, 32'h0000_0000, value driven on out_pc while out_valid=0.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- flush  in  1  drop all buffered entries (redirect from branch/jump).
- in_valid  in  1  fetch beat valid.
- in_ready  out  1  stage can accept a beat (registered).
- in_instr  in  32  raw instruction.
- in_pc  in  32  instruction address.
- out_valid  out  1  decoded beat valid.
- out_ready  in  1  execute accepts beat.
- out_instr  out  32  buffered instruction.
- out_pc  out  32  buffered PC.
- out_fmt  out  3  format code: R=0, I=1, S=2, B=3, U=4, J=5, NONE=7.
- out_imm  out  32  sign-extended immediate (0 for R/NONE).
- out_illegal  out  1  unknown opcode flag (see Optional Feature).

Behaviour:
- Reset (rst_n=0 at a clock edge): state=EMPTY, in_ready=1, out_valid=0, out_instr=0, out_pc=RESET_PC_TAG, out_fmt=7, out_imm=0, out_illegal=0. Reset overrides flush and any handshake in the same cycle, including mid-transfer; buffered beats are lost.
- Handshakes:
  - An input transfer occurs when in_valid & in_ready at a clock edge.
  - An output transfer occurs when out_valid & out_ready at a clock edge.
  - Once out_valid=1, out_* stay stable until the output transfer completes.
- Decode: format and immediate are computed combinationally from in_instr and registered with the beat. Latency is 1 cycle from input transfer to out_valid when the stage was EMPTY.
- Immediate rules:
  - I: sign-extend instr[31:20].
  - S: sign-extend {instr[31:25], instr[11:7]}.
  - B: sign-extend {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U: {instr[31:12], 12'b0}.
  - J: sign-extend {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
- Opcode to format:
  - 0110011 -> R.
  - 0010011, 0000011, 1100111, 1110011, 0001111 -> I.
  - 0100011 -> S.
  - 1100011 -> B.
  - 0110111, 0010111 -> U.
  - 1101111 -> J.
  - all other opcodes -> NONE.
- States (main register M, skid register K):
  - EMPTY: in_ready=1, out_valid=0. Input transfer -> FULL (load M).
  - FULL: in_ready=1, out_valid=1, outputs driven from M.
    - in & out transfer together: reload M, stay FULL.
    - out transfer only: -> EMPTY.
    - in transfer only: load K, -> SKID.
  - SKID: in_ready=0, out_valid=1 from M.
    - out transfer: M<=K, -> FULL.
- in_ready is a registered function of the next state; a new beat presented in SKID is not accepted.
- flush=1 at an edge: -> EMPTY. Any beat accepted in that same cycle is discarded. out_valid=0 and in_ready=1 next cycle.
- Simultaneous flush and output transfer: the transfer counts as completed; the entry is still removed.
- Beat ordering is strictly preserved; no beat is duplicated or dropped except by flush or reset.

Optional Feature:
- Macro DECODE_ILLEGAL_TRAP_EN.
- Defined:
  - out_illegal=1 with a beat whose fmt=NONE.
  - After that beat leaves the output, the stage enters HALT: in_ready=0, out_valid=0.
  - HALT is left only by flush or reset (-> EMPTY).
- Undefined: out_illegal is tied 0; NONE beats pass through with out_imm=0; HALT does not exist.

Decomposition:
- Package decode_pkg:
  - opcode localparams (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, SYSTEM, MISC_MEM).
  - 3-bit format codes FMT_R..FMT_NONE.
  - state encodings EMPTY/FULL/SKID/HALT.
- One natural sub-module: the existing immediate generator, instantiated once on in_instr.
- Format classification stays inline as a case on opcode.

Test Plan:
- Reset then in_instr=32'hFFF00093 (addi x1,x0,-1), pc=0x100, out_ready=1 -> next cycle out_valid=1, fmt=1, imm=32'hFFFFFFFF, pc=0x100.
- Back-to-back 32'hFE000EE3 (beq -4), 32'h123452B7 (lui x5,0x12345), 32'h001000EF (jal x1,2048) -> imm 32'hFFFFFFFC/fmt 3, 32'h12345000/fmt 4, 32'h00000800/fmt 5, in order, one per cycle.
- out_ready=0, present three beats -> first two accepted, in_ready=0 after the second, third held. Raise out_ready -> all three emerge in order with stable outputs while stalled.
- State SKID, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1; flushed beats never appear.
- rst_n=0 for one edge while in SKID -> all outputs at reset values the next cycle, no stale beat later.
- With DECODE_ILLEGAL_TRAP_EN, send 32'h0000007F -> out_illegal=1, fmt=7, then in_ready=0 until flush. Without the macro -> fmt=7, out_illegal=0, the next beat flows normally.
